nvram_hps_arbiter: RTL
======================

NVRAM_HPS_ARBITER -- requirements
Module: nvram_hps_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, NVRAM address width (256 bytes).
REQ-002 SHALL have clk  in  1  10 MHz system clock.
REQ-003 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have cpu_sel_n  in  1  CPU NVRAM select, 0x9000-0x93FF decode.
REQ-005 SHALL have cpu_wr_n  in  1  CPU write strobe, WRphi2n, active-low.
REQ-006 SHALL have cpu_addr  in  AW  CPU byte address.
REQ-007 SHALL have cpu_wdata  in  8  CPU write data.
REQ-008 SHALL have cpu_rdata  out  8  registered read data to CPU.
REQ-009 SHALL have store  in  1  game STORE command, level.
REQ-010 SHALL have ioctl_download  in  1  HPS loading a saved NVRAM image.
REQ-011 SHALL have ioctl_upload  in  1  HPS reading NVRAM for save.
REQ-012 SHALL have ioctl_wr  in  1  single-cycle HPS write strobe.
REQ-013 SHALL have ioctl_addr  in  AW  HPS byte address.
REQ-014 SHALL have ioctl_dout  in  8  HPS write data.
REQ-015 SHALL have ioctl_din  out  8  upload data to HPS.
REQ-016 SHALL have ioctl_wait  out  1  HPS stall request.
REQ-017 SHALL have nv_dirty  out  1  NVRAM changed since last upload; request save.

Function
REQ-018 SHALL own one 256x8 single-port RAM with 1-cycle synchronous read; it is the only NVRAM store.
REQ-019 SHALL detect a CPU write on the first clk where cpu_sel_n=0 and cpu_wr_n=0 (previous cycle not both low); exactly one RAM write per strobe.
REQ-020 SHALL give the CPU write priority; a CPU write is never delayed or dropped.
REQ-021 SHALL read RAM at cpu_addr every idle cycle while cpu_sel_n=0; cpu_rdata updates 1 cycle after address and holds otherwise.
REQ-022 FSM states SHALL be IDLE, HPS_WR, UL_RD, UL_DATA.
REQ-023 IDLE: ioctl_download & ioctl_wr -> latch ioctl_addr/ioctl_dout, assert ioctl_wait, go to HPS_WR.
REQ-024 HPS_WR: write pending byte on first cycle with no CPU write; same cycle deassert ioctl_wait, go to IDLE; if CPU writes that cycle, stay in HPS_WR.
REQ-025 IDLE: ioctl_upload & ioctl_addr differs from last-fetched address (or first cycle of upload) -> assert ioctl_wait, go to UL_RD.
REQ-026 UL_RD: issue RAM read at ioctl_addr when no CPU access that cycle; go to UL_DATA; otherwise stay.
REQ-027 UL_DATA: register RAM output into ioctl_din, record fetched address, deassert ioctl_wait, go to IDLE; worst-case upload latency 2 cycles plus CPU-contention cycles.
REQ-028 ioctl_wr when ioctl_download=0 SHALL be ignored.
REQ-029 download and upload both high SHALL be treated as download only.
REQ-030 ioctl_download or ioctl_upload falling mid-sequence SHALL return to IDLE next cycle, drop any pending byte, and deassert ioctl_wait.
REQ-031 nv_dirty SHALL set on the rising edge of store when at least one CPU write has occurred since the last clear.
REQ-032 nv_dirty SHALL clear on the falling edge of ioctl_upload, and on the falling edge of ioctl_download.
REQ-033 If a set and a clear of nv_dirty coincide, set SHALL win.
REQ-034 Address arithmetic SHALL be AW bits, with no wrap logic beyond natural truncation.

Reset
REQ-035 On reset: FSM=IDLE; cpu_rdata=0x00; ioctl_din=0x00; ioctl_wait=0; nv_dirty=0; write-seen flag, edge registers and pending registers cleared.
REQ-036 RAM contents SHALL NOT be cleared by reset.
REQ-037 reset_n asserted mid-transfer SHALL abort the transfer immediately.

Structure
REQ-038 A shared package SHALL hold NV_AW=8 and the FSM state enumeration.
REQ-039 The RAM SHALL be one sub-module, nvram_mem: 256x8, 1-cycle registered read, single write port.

Verification
REQ-040 Download 0x00..0xFF = addr^0x5A, then CPU reads addr 0x10 -> cpu_rdata=0x4A one cycle later.
REQ-041 ioctl_wr coinciding with a CPU write to 0x20 (0x77, HPS 0x11) -> CPU byte lands on the first cycle, ioctl_wait=1 for one extra cycle, HPS byte next cycle; both bytes readable.
REQ-042 CPU writes 0x33 to 0x05, store pulse -> nv_dirty=1; upload reads 0x05 -> ioctl_din=0x33 within 2 cycles of address change; upload falls -> nv_dirty=0.
REQ-043 store pulse with no prior CPU write -> nv_dirty stays 0.
REQ-044 ioctl_download drops while in HPS_WR -> byte not written, ioctl_wait=0 next cycle, FSM IDLE.
REQ-045 reset_n pulsed during UL_RD -> all outputs at reset values; RAM data written earlier preserved.

Source files
------------

// File: rtl/nvram_hps_arbiter_pkg.sv
// Shared constants and FSM state encoding for the NVRAM / HPS arbiter.
package nvram_hps_arbiter_pkg;

  localparam int NV_AW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HPS_WR  = 2'd1,
    UL_RD   = 2'd2,
    UL_DATA = 2'd3
  } nv_state_e;

endpackage

// File: rtl/nvram_hps_arbiter_mem.sv
// Single-port NVRAM store: one write port, registered read (read-old on collision).
// Contents are deliberately not reset so saved data survives a core reset.
module nvram_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Synchronous write and 1-cycle registered read at the shared address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nvram_hps_arbiter.sv
// Arbitrates the single NVRAM port between the game CPU (always wins) and the
// HPS ioctl download/upload path; tracks whether NVRAM needs saving.
module nvram_hps_arbiter
  import nvram_hps_arbiter_pkg::*;
#(
  parameter int AW = NV_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_sel_n,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  input  logic          store,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          nv_dirty
);

  nv_state_e     state, state_nxt;
  logic          cpu_wr_q, store_q, dl_q, ul_q;
  logic          cpu_wr_stb, cpu_rd, ul_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [AW-1:0] pend_addr, ul_addr_q, fetched_addr;
  logic [7:0]    pend_data, cpu_hold;
  logic          fetched_vld, rd_cpu_q, wr_seen;
  logic          dirty_set, dirty_clr, ul_only;

  // A CPU write is the first cycle of select+strobe both low.
  assign cpu_wr_stb = ~cpu_sel_n & ~cpu_wr_n & ~cpu_wr_q;
  // Download overrides upload when both are raised.
  assign ul_only    = ioctl_upload & ~ioctl_download;
  assign ioctl_wait = (state != IDLE);
  // Read data appears the cycle after a CPU read issue and holds otherwise.
  assign cpu_rdata  = rd_cpu_q ? mem_rdata : cpu_hold;

  nvram_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Port owner per cycle: CPU write, pending HPS write, CPU read, upload read.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rd    = 1'b0;
    ul_rd     = 1'b0;
    if (cpu_wr_stb) begin
      mem_we = 1'b1;
    end else if (state == HPS_WR && ioctl_download) begin
      mem_we    = 1'b1;
      mem_addr  = pend_addr;
      mem_wdata = pend_data;
    end else if (!cpu_sel_n) begin
      cpu_rd = 1'b1;
    end else if (state == UL_RD && ul_only) begin
      ul_rd    = 1'b1;
      mem_addr = ioctl_addr;
    end
  end

  // Next-state logic; losing the ioctl level aborts back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ioctl_download) begin
          if (ioctl_wr) state_nxt = HPS_WR;
        end else if (ioctl_upload &&
                     (!fetched_vld || ioctl_addr != fetched_addr)) begin
          state_nxt = UL_RD;
        end
      end
      HPS_WR:  if (!ioctl_download || !cpu_wr_stb) state_nxt = IDLE;
      UL_RD: begin
        if (!ul_only)   state_nxt = IDLE;
        else if (ul_rd) state_nxt = UL_DATA;
      end
      UL_DATA: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath registers: pending HPS byte, upload fetch, CPU read hold, edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_wr_q     <= 1'b0;
      store_q      <= 1'b0;
      dl_q         <= 1'b0;
      ul_q         <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= 8'h00;
      ul_addr_q    <= '0;
      fetched_addr <= '0;
      fetched_vld  <= 1'b0;
      ioctl_din    <= 8'h00;
      rd_cpu_q     <= 1'b0;
      cpu_hold     <= 8'h00;
    end else begin
      cpu_wr_q <= ~cpu_sel_n & ~cpu_wr_n;
      store_q  <= store;
      dl_q     <= ioctl_download;
      ul_q     <= ioctl_upload;
      rd_cpu_q <= cpu_rd;
      cpu_hold <= cpu_rdata;
      if (state == IDLE && ioctl_download && ioctl_wr) begin
        pend_addr <= ioctl_addr;
        pend_data <= ioctl_dout;
      end
      if (ul_rd) ul_addr_q <= ioctl_addr;
      if (!ioctl_upload) begin
        fetched_vld <= 1'b0;
      end else if (state == UL_DATA && ul_only) begin
        ioctl_din    <= mem_rdata;
        fetched_addr <= ul_addr_q;
        fetched_vld  <= 1'b1;
      end
    end
  end

  assign dirty_set = store & ~store_q & (wr_seen | cpu_wr_stb);
  assign dirty_clr = (ul_q & ~ioctl_upload) | (dl_q & ~ioctl_download);

  // Save request: set on STORE after a CPU write, cleared when HPS finishes; set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_seen  <= 1'b0;
      nv_dirty <= 1'b0;
    end else begin
      if (cpu_wr_stb)     wr_seen <= 1'b1;
      else if (dirty_clr) wr_seen <= 1'b0;
      if (dirty_set)      nv_dirty <= 1'b1;
      else if (dirty_clr) nv_dirty <= 1'b0;
    end
  end

endmodule
